bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 132 +++++++++++++
 tb/tb_bus_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the ICache/DCache/DMA masters onto one slave bus.
// The grant is registered and the address/data path is muxed combinationally from the current owner.
module bus_arbiter #(
  parameter int NMASTERS = 3,
  parameter int MAX_HOLD = 64
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [NMASTERS-1:0]      m_req,
  output logic [NMASTERS-1:0]      m_ack,
  input  logic [32*NMASTERS-1:0]   m_addr,
  input  logic [32*NMASTERS-1:0]   m_wdata,
  input  logic [NMASTERS-1:0]      m_rd,
  input  logic [NMASTERS-1:0]      m_wr,
  output logic [31:0]              m_rdata,
  output logic [NMASTERS-1:0]      m_ready,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic                     s_rd,
  output logic                     s_wr,
  input  logic [31:0]              s_rdata,
  input  logic                     s_ready
);

  // state | meaning
  // IDLE  | no owner; arbitrate from last_owner+1
  // GRANT | owner holds the bus, ack and slave path enabled
  // TURN  | one dead cycle after a release; arbitrate from owner+1
  localparam int OW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;

  logic [1:0]          state;
  logic [OW-1:0]       owner;
  logic [OW-1:0]       last_owner;
  logic [OW-1:0]       rr_base;
  logic [OW-1:0]       pick;
  logic [HW-1:0]       hold_cnt;
  logic [NMASTERS-1:0] owner_oh;
  logic                granted;
  logic                other_req;
  logic                forced;
  logic                release_now;

  assign granted   = (state == GRANT);
  assign owner_oh  = NMASTERS'(1) << owner;
  assign other_req = |(m_req & ~owner_oh);
  // TURN arbitrates before last_owner has caught up, so rotate from the outgoing owner
  assign rr_base   = (state == TURN) ? owner : last_owner;

  always_comb begin
    int idx;
    idx  = 0;
    pick = rr_base;
    for (int i = NMASTERS; i >= 1; i--) begin
      idx = (int'(rr_base) + i) % NMASTERS;
      if (m_req[idx]) pick = OW'(idx);
    end
  end

  assign forced      = (MAX_HOLD != 0) && other_req && (hold_cnt == HW'(MAX_HOLD - 1));
  assign release_now = !m_req[owner] || forced;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      owner      <= OW'(NMASTERS - 1);
      last_owner <= OW'(NMASTERS - 1);
      hold_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (|m_req) begin
            state <= GRANT;
            owner <= pick;
          end
        end
        GRANT: begin
          if (release_now) begin
            state    <= TURN;
            hold_cnt <= '0;
          end else if (other_req && (hold_cnt != '1)) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        TURN: begin
          last_owner <= owner;
          hold_cnt   <= '0;
          if (|m_req) begin
            state <= GRANT;
            owner <= pick;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    m_ack   = '0;
    m_ready = '0;
    s_addr  = '0;
    s_wdata = '0;
    s_rd    = 1'b0;
    s_wr    = 1'b0;
    if (granted) begin
      m_ack   = owner_oh;
      m_ready = owner_oh & {NMASTERS{s_ready}};
      s_addr  = m_addr[32*int'(owner) +: 32];
      s_wdata = m_wdata[32*int'(owner) +: 32];
      s_rd    = m_rd[owner];
      // read wins when a master drives both strobes
      s_wr    = m_wr[owner] & ~m_rd[owner];
    end
  end

  assign m_rdata = s_rdata;

  always @(posedge clk) begin
    if (rst_b && granted && m_rd[owner] && m_wr[owner])
      $display("bus_arbiter warning: master %0d drives rd and wr together, write suppressed", owner);
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: two instances share stimulus, one with MAX_HOLD=4, one with MAX_HOLD=1.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [2:0]  m_req, m_rd, m_wr;
  logic [95:0] m_addr, m_wdata;
  logic [31:0] s_rdata;
  logic        s_ready;

  logic [2:0]  ack_a, rdy_a, ack_b, rdy_b;
  logic [31:0] rdata_a, saddr_a, swdata_a, rdata_b, saddr_b, swdata_b;
  logic        srd_a, swr_a, srd_b, swr_b;

  int n_vec = 0;
  int n_bad = 0;
  int beats;
  logic [2:0] rr_exp [8] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};

  always #5 clk = ~clk;

  bus_arbiter #(.NMASTERS(3), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst_b(rst_b), .m_req(m_req), .m_ack(ack_a), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rd(m_rd), .m_wr(m_wr), .m_rdata(rdata_a), .m_ready(rdy_a), .s_addr(saddr_a),
    .s_wdata(swdata_a), .s_rd(srd_a), .s_wr(swr_a), .s_rdata(s_rdata), .s_ready(s_ready));

  bus_arbiter #(.NMASTERS(3), .MAX_HOLD(1)) dut_b (
    .clk(clk), .rst_b(rst_b), .m_req(m_req), .m_ack(ack_b), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rd(m_rd), .m_wr(m_wr), .m_rdata(rdata_b), .m_ready(rdy_b), .s_addr(saddr_b),
    .s_wdata(swdata_b), .s_rd(srd_b), .s_wr(swr_b), .s_rdata(s_rdata), .s_ready(s_ready));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    m_req = 3'b000; m_rd = 3'b000; m_wr = 3'b000;
    m_addr = '0; m_wdata = '0; s_rdata = '0; s_ready = 1'b0;

    // reset, then release with masters 0 and 1 already requesting
    #3 m_req = 3'b011;
    #1;
    chk("rst_ack_a", 32'(ack_a), 32'h0);
    chk("rst_srd_a", 32'(srd_a), 32'h0);
    chk("rst_ack_b", 32'(ack_b), 32'h0);
    @(negedge clk) rst_b = 1'b1;
    cyc(); chk("first_grant", 32'(ack_a), 32'h1);
    m_req = 3'b010;
    cyc(); chk("drop_turn", 32'(ack_a), 32'h0);
    cyc(); chk("next_grant1", 32'(ack_a), 32'h2);
    m_req = 3'b000;
    cyc(); chk("rel_turn", 32'(ack_a), 32'h0);
    cyc(); chk("idle", 32'(ack_a), 32'h0);

    // read by master 0 while master 1 waits
    m_req   = 3'b011; m_rd = 3'b001;
    m_addr  = {32'h0000_3000, 32'h0000_2000, 32'h0000_1040};
    m_wdata = {32'h0000_3333, 32'h0000_5555, 32'hCAFE_0001};
    s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
    cyc();
    chk("txn_ack", 32'(ack_a), 32'h1);
    chk("txn_saddr", saddr_a, 32'h0000_1040);
    chk("txn_swdata", swdata_a, 32'hCAFE_0001);
    chk("txn_srd", 32'(srd_a), 32'h1);
    chk("txn_swr", 32'(swr_a), 32'h0);
    chk("txn_ready", 32'(rdy_a), 32'h1);
    chk("txn_rdata", rdata_a, 32'hDEAD_BEEF);
    m_wr = 3'b001;
    #1;
    chk("rdwr_swr", 32'(swr_a), 32'h0);
    chk("rdwr_srd", 32'(srd_a), 32'h1);
    m_rd = 3'b000;
    #1;
    chk("wr_swr", 32'(swr_a), 32'h1);
    chk("wr_srd", 32'(srd_a), 32'h0);
    m_wr = 3'b000;

    // contended hold limit of 4 on dut_a
    for (int i = 2; i <= 4; i++) begin
      cyc(); chk("hold0", 32'(ack_a), 32'h1);
    end
    cyc(); chk("forced_turn0", 32'(ack_a), 32'h0);
    cyc(); chk("hold1_start", 32'(ack_a), 32'h2);
    chk("hold1_ready", 32'(rdy_a), 32'h2);
    for (int i = 2; i <= 4; i++) begin
      cyc(); chk("hold1", 32'(ack_a), 32'h2);
    end
    cyc(); chk("forced_turn1", 32'(ack_a), 32'h0);
    cyc(); chk("back_to0", 32'(ack_a), 32'h1);
    m_req = 3'b010;
    cyc(); chk("rel0_turn", 32'(ack_a), 32'h0);
    cyc(); chk("regain1", 32'(ack_a), 32'h2);

    // all three requesting, MAX_HOLD=1 on dut_b
    rst_b = 1'b0;
    m_req = 3'b111;
    #1;
    chk("rst2_ack_b", 32'(ack_b), 32'h0);
    @(negedge clk) rst_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("rr_order%0d", i), 32'(ack_b), 32'(rr_exp[i]));
      chk("onehot_b", 32'($countones(ack_b) <= 1), 32'h1);
      chk("onehot_a", 32'($countones(ack_a) <= 1), 32'h1);
    end

    // reset mid ICache fill, then the fill is re-granted and runs to completion
    rst_b = 1'b0;
    m_req = 3'b001; m_rd = 3'b001; m_addr = {32'h0, 32'h0, 32'h0000_0100};
    @(negedge clk) rst_b = 1'b1;
    cyc(); chk("fill_grant", 32'(ack_a), 32'h1);
    for (int i = 0; i < 4; i++) cyc();
    chk("fill_mid_srd", 32'(srd_a), 32'h1);
    rst_b = 1'b0;
    #1;
    chk("fill_rst_ack", 32'(ack_a), 32'h0);
    chk("fill_rst_srd", 32'(srd_a), 32'h0);
    chk("fill_rst_rdy", 32'(rdy_a), 32'h0);
    #3 rst_b = 1'b1;
    cyc(); chk("fill_regrant", 32'(ack_a), 32'h1);
    chk("fill_regrant_srd", 32'(srd_a), 32'h1);
    beats = 0;
    for (int i = 0; i < 16; i++) begin
      if (rdy_a[0] === 1'b1 && srd_a === 1'b1) beats++;
      if (i == 15) begin
        m_req = 3'b000; m_rd = 3'b000;
      end
      cyc();
    end
    chk("fill_beats", 32'(beats), 32'd16);
    chk("fill_done_turn", 32'(ack_a), 32'h0);
    cyc(); chk("fill_done_idle", 32'(ack_a), 32'h0);
    chk("fill_done_srd", 32'(srd_a), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
